mul_arbiter: RTL and testbench

Shares one serial_multiplier instance among N_REQ requesters using round-robin arbitration. Each accepted job is latched, sequenced into the multiplier with a one-cycle start pulse, and watched for completion. The product (or a timeout error) is returned to the originating requester over a valid/ready response channel. The block sits between bus-side requesters (e.g. APB slave front-ends) and the multiplier datapath.

---
 rtl/mul_arb_pkg.sv | 20 ++
 rtl/mul_arbiter_rr_picker.sv | 38 +++
 rtl/mul_arbiter.sv | 142 ++++++++++++++
 tb/tb_mul_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and width helpers for the multiplier arbiter.
// Imported by the arbiter top and its round-robin picker.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } state_t;

  function automatic int res_w(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// Combinational round-robin picker: searches req from ptr+1 upward.
// Emits a one-hot grant, its encoded index and an any-request flag.
module rr_picker
  import mul_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int          j;
  logic [IW-1:0] jj;

  // Walk from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = N; k >= 1; k--) begin
      j  = (int'(ptr_i) + k) % N;
      jj = IW'(j);
      if (req_i[jj]) begin
        gnt_o     = '0;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one serial multiplier among requesters.
// One job in flight; results or timeouts return on a valid/ready channel.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int  N_REQ      = 4,
  parameter int  OP_X_WIDTH = 16,
  parameter int  OP_Y_WIDTH = 16,
  parameter int  TIMEOUT    = 255,
  localparam int RES_WIDTH  = res_w(OP_X_WIDTH, OP_Y_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*OP_X_WIDTH-1:0] req_x,
  input  logic [N_REQ*OP_Y_WIDTH-1:0] req_y,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  input  logic [N_REQ-1:0]            resp_ready,
  output logic [RES_WIDTH-1:0]        resp_data,
  output logic                        resp_err,
  output logic                        mul_start,
  output logic [OP_X_WIDTH-1:0]       mul_x,
  output logic [OP_Y_WIDTH-1:0]       mul_y,
  input  logic                        mul_valid,
  input  logic [RES_WIDTH-1:0]        mul_out,
  output logic                        busy
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                  state_q;
  logic [IW-1:0]           ptr_q;
  logic [IW-1:0]           gnt_q;
  logic [CW-1:0]           cnt_q;
  logic                    seen_low_q;
  logic                    mul_start_q;
  logic [OP_X_WIDTH-1:0]   mul_x_q;
  logic [OP_Y_WIDTH-1:0]   mul_y_q;
  logic [N_REQ-1:0]        resp_valid_q;
  logic [RES_WIDTH-1:0]    resp_data_q;
  logic                    resp_err_q;

  logic [N_REQ-1:0]        pick_gnt;
  logic [IW-1:0]           pick_idx;
  logic                    pick_any;
  logic [OP_X_WIDTH-1:0]   sel_x;
  logic [OP_Y_WIDTH-1:0]   sel_y;
  logic [N_REQ-1:0]        gnt_oh;

  rr_picker #(
    .N (N_REQ)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_x = req_x[i*OP_X_WIDTH +: OP_X_WIDTH];
        sel_y = req_y[i*OP_Y_WIDTH +: OP_Y_WIDTH];
      end
    end
  end

  assign gnt_oh     = N_REQ'(1) << gnt_q;
  assign req_ready  = (state_q == IDLE) ? pick_gnt : '0;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mul_start  = mul_start_q;
  assign mul_x      = mul_x_q;
  assign mul_y      = mul_y_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= IW'(N_REQ - 1);
      gnt_q        <= '0;
      cnt_q        <= '0;
      seen_low_q   <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            mul_x_q     <= sel_x;
            mul_y_q     <= sel_y;
            gnt_q       <= pick_idx;
            ptr_q       <= pick_idx;
            mul_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          mul_start_q <= 1'b0;
          cnt_q       <= '0;
          seen_low_q  <= !mul_valid;
          state_q     <= BUSY;
        end
        BUSY: begin
          if (!mul_valid) seen_low_q <= 1'b1;
          // A high valid is trusted only after a low has been observed.
          if (mul_valid && seen_low_q) begin
            resp_data_q  <= mul_out;
            resp_err_q   <= 1'b0;
            resp_valid_q <= gnt_oh;
            state_q      <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= gnt_oh;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready[gnt_q]) begin
            resp_valid_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomised + directed bench for mul_arbiter with a stub multiplier.
// A scoreboard tracks the in-flight job and the round-robin order.
module tb_mul_arbiter;

  localparam int N  = 4;
  localparam int XW = 16;
  localparam int YW = 16;
  localparam int RW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*XW-1:0] req_x;
  logic [N*YW-1:0] req_y;
  logic [RW-1:0]   resp_data, mul_out;
  logic            resp_err, mul_start, mul_valid, busy;
  logic [XW-1:0]   mul_x;
  logic [YW-1:0]   mul_y;

  mul_arbiter #(
    .N_REQ(N), .OP_X_WIDTH(XW), .OP_Y_WIDTH(YW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_valid(mul_valid), .mul_out(mul_out),
    .busy(busy)
  );

  // stub multiplier: valid stays high until the next start
  bit            dead;
  int            lat, stale_k;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  int            stl, lc;
  bit            pend;
  logic          mv;
  logic [RW-1:0] mo;
  assign mul_valid = mv;
  assign mul_out   = mo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 1'b0; mo <= '0; pend <= 1'b0; stl <= 0; lc <= 0;
      sx <= '0; sy <= '0;
    end else if (mul_start) begin
      sx <= mul_x; sy <= mul_y; stl <= stale_k; lc <= lat;
      pend <= !dead;
      if (dead || stale_k == 0) mv <= 1'b0;
    end else if (pend) begin
      if (stl > 0) stl <= stl - 1;
      else if (lc <= 1) begin
        mv <= 1'b1; mo <= RW'(sx) * RW'(sy); pend <= 1'b0;
      end else begin
        mv <= 1'b0; lc <= lc - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int            idx;
    logic [RW-1:0] data;
    bit            err;
  } ent_t;
  ent_t log_q[$];

  logic [XW-1:0] rx[N];
  logic [YW-1:0] ry[N];
  bit [N-1:0]    acc;
  bit            cont, rnd, inflight, exp_err, seen_resp;
  int            mptr, exp_idx, acc_cyc, cyc, nstart;
  logic [RW-1:0] exp_data;
  logic [XW-1:0] ex_x;
  logic [YW-1:0] ex_y;

  task automatic set_req(input int i, input logic [XW-1:0] x,
                         input logic [YW-1:0] y);
    rx[i] = x;
    ry[i] = y;
    req_x[i*XW +: XW] = x;
    req_y[i*YW +: YW] = y;
    req_valid[i] = 1'b1;
  endtask

  task automatic observe();
    int win;
    bit pre;
    logic [N-1:0] exp_rdy;
    cyc++;
    pre = inflight;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (win < 0 && req_valid[j]) win = j;
    end
    exp_rdy = (!pre && win >= 0) ? N'(1) << win : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(pre));
    chk("mul_start", 64'(mul_start), 64'(pre && cyc == acc_cyc + 1));
    if (mul_start) nstart++;
    if (pre) begin
      chk("mul_x", 64'(mul_x), 64'(ex_x));
      chk("mul_y", 64'(mul_y), 64'(ex_y));
    end
    if (!pre) chk("resp_idle", 64'(resp_valid), 64'(0));
    else if (resp_valid != '0) begin
      chk("resp_valid", 64'(resp_valid), 64'(N'(1) << exp_idx));
      chk("resp_data", 64'(resp_data), 64'(exp_data));
      chk("resp_err", 64'(resp_err), 64'(exp_err));
      if (!seen_resp) begin
        seen_resp = 1'b1;
        if (exp_err) chk("tmo_lat", 64'(cyc - acc_cyc), 64'(TO + 2));
      end
      if (resp_ready[exp_idx]) begin
        inflight = 1'b0;
        log_q.push_back('{exp_idx, resp_data, resp_err});
      end
    end
    if (!pre && win >= 0) begin
      inflight  = 1'b1;
      exp_idx   = win;
      mptr      = win;
      ex_x      = rx[win];
      ex_y      = ry[win];
      exp_err   = dead;
      exp_data  = dead ? '0 : RW'(rx[win]) * RW'(ry[win]);
      acc_cyc   = cyc;
      seen_resp = 1'b0;
      acc[win]  = 1'b1;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rnd) begin
        if (acc[i]) begin
          acc[i] = 1'b0;
          req_valid[i] = 1'b0;
          if ($urandom_range(0, 1) == 1)
            set_req(i, XW'($urandom), YW'($urandom));
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, XW'($urandom), YW'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
        resp_ready[i] = ($urandom_range(0, 3) != 0);
      end else if (acc[i]) begin
        acc[i] = 1'b0;
        if (!cont) req_valid[i] = 1'b0;
      end
    end
    if (rnd && !inflight) begin
      dead    = ($urandom_range(0, 9) == 0);
      lat     = $urandom_range(2, 6);
      stale_k = $urandom_range(0, 4);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_n) observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_resp(input int n, input int budget);
    int target;
    target = log_q.size() + n;
    for (int k = 0; k < budget && log_q.size() < target; k++) step();
    chk("wait_resp", 64'(log_q.size()), 64'(target));
  endtask

  task automatic chk_ent(input string tag, input int pos, input int idx,
                         input logic [RW-1:0] data, input bit err);
    if (pos < log_q.size()) begin
      chk({tag, "_idx"}, 64'(log_q[pos].idx), 64'(idx));
      chk({tag, "_data"}, 64'(log_q[pos].data), 64'(data));
      chk({tag, "_err"}, 64'(log_q[pos].err), 64'(err));
    end else begin
      chk({tag, "_missing"}, 64'(log_q.size()), 64'(pos + 1));
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, "_mul_start"}, 64'(mul_start), 64'(0));
    chk({tag, "_resp_err"}, 64'(resp_err), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_mul_x"}, 64'(mul_x), 64'(0));
    chk({tag, "_mul_y"}, 64'(mul_y), 64'(0));
    chk({tag, "_resp_data"}, 64'(resp_data), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0;
    bit found;
    rst_n = 1'b0;
    req_valid = '0; req_x = '0; req_y = '0; resp_ready = '1;
    dead = 1'b0; lat = 3; stale_k = 0;
    cont = 1'b0; rnd = 1'b0; inflight = 1'b0; acc = '0;
    mptr = N - 1; cyc = 0; acc_cyc = -10; nstart = 0;
    for (int i = 0; i < N; i++) begin rx[i] = '0; ry[i] = '0; end
    #12;
    chk_zero_outs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all requesters continuously: order 0,1,2,3,0
    base = log_q.size();
    cont = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, XW'(i + 2), YW'(10));
    wait_resp(5, 200);
    cont = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 5; k++)
      chk_ent("rr", base + k, k % N, RW'(((k % N) + 2) * 10), 1'b0);

    // single job from requester 0
    base = log_q.size();
    n0 = nstart;
    set_req(0, 3, 7);
    wait_resp(1, 50);
    chk_ent("single", base, 0, 21, 1'b0);
    chk("single_starts", 64'(nstart - n0), 64'(1));
    step();
    chk("single_idle", 64'(busy), 64'(0));

    // response stall on requester 2
    base = log_q.size();
    resp_ready = 4'b1011;
    set_req(2, 10, 10);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      step();
      found = resp_valid[2];
    end
    chk("stall_seen", 64'(found), 64'(1));
    set_req(0, 1, 1);
    repeat (5) step();
    chk("stall_hold", 64'(resp_valid), 64'(4'b0100));
    chk("stall_data", 64'(resp_data), 64'(100));
    resp_ready = '1;
    wait_resp(2, 60);
    chk_ent("stall", base, 2, 100, 1'b0);
    chk_ent("after_stall", base + 1, 0, 1, 1'b0);

    // stale valid from the previous product
    base = log_q.size();
    stale_k = 3;
    set_req(1, 9, 9);
    wait_resp(1, 60);
    chk_ent("stale", base, 1, 81, 1'b0);
    stale_k = 0;

    // timeout then a normal job
    base = log_q.size();
    dead = 1'b1;
    set_req(3, 11, 13);
    wait_resp(1, 60);
    chk_ent("tmo", base, 3, 0, 1'b1);
    dead = 1'b0;
    set_req(3, 7, 8);
    wait_resp(1, 60);
    chk_ent("post_tmo", base + 1, 3, 56, 1'b0);

    // reset in the middle of a job
    dead = 1'b1;
    set_req(2, 4, 4);
    repeat (6) step();
    chk("rst_pre_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_zero_outs("midrst");
    inflight = 1'b0; mptr = N - 1; acc = '0; req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    dead = 1'b0;
    rst_n = 1'b1;
    base = log_q.size();
    set_req(0, 5, 6);
    set_req(1, 1, 2);
    set_req(2, 3, 4);
    set_req(3, 5, 5);
    wait_resp(1, 60);
    chk_ent("post_rst", base, 0, 30, 1'b0);
    wait_resp(3, 150);
    chk_ent("post_rst_last", base + 3, 3, 25, 1'b0);

    // randomized traffic against the scoreboard
    rnd = 1'b1;
    repeat (1500) step();
    rnd = 1'b0;
    dead = 1'b0;
    req_valid = '0;
    resp_ready = '1;
    for (int k = 0; k < 100 && inflight; k++) step();
    chk("drain", 64'(inflight), 64'(0));
    step();
    chk("final_idle", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
